// File: rtl/mbus_ice_driver_tx.sv
// Host-to-MBus transmit path of the ICE bridge: collects a byte-serial send request,
// drives pend-chained MBus TX words, and writes a 3-byte response into the host buffer.
module mbus_ice_driver_tx #(
  parameter logic [7:0]  RESP_CODE = 8'h00,
  parameter int unsigned TIMEOUT   = 1048575,
  parameter int unsigned TO_W      = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  host_data,
  input  logic        host_valid,
  input  logic        host_last,
  input  logic [7:0]  host_eid,
  input  logic        host_priority,
  output logic        host_ready,
  output logic [31:0] mbus_tx_addr,
  output logic [31:0] mbus_tx_data,
  output logic        mbus_tx_req,
  output logic        mbus_tx_pend,
  output logic        mbus_tx_priority,
  input  logic        mbus_tx_ack,
  input  logic        mbus_tx_succ,
  input  logic        mbus_tx_fail,
  output logic        buffer_request,
  input  logic        buffer_grant,
  output logic [7:0]  buffer_data,
  output logic        buffer_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_RESULT, S_DRAIN,
    S_RESP_REQ, S_RESP_CODE, S_RESP_EID, S_RESP_STAT
  } state_t;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_NAK     = 8'h01;
  localparam logic [7:0] ST_MAL     = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      eid_q;
  logic            prio_q;
  logic [7:0]      status_q;
  logic            malformed;
  logic            last_seen;

  logic            take;
  logic [31:0]     word_shift;
  logic [31:0]     word_pad;

  assign take = host_valid && host_ready;

  // A word cut short by host_last keeps its received bytes at the top, zeros below.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    word_shift = {mbus_tx_data[23:0], host_data};
    word_pad   = word_shift;
    case (byte_cnt)
      2'd0:    word_pad = {host_data, 24'h0};
      2'd1:    word_pad = {mbus_tx_data[7:0], host_data, 16'h0};
      2'd2:    word_pad = {mbus_tx_data[15:0], host_data, 8'h0};
      default: word_pad = word_shift;
    endcase
  end

  // NOTE: the async reset clears every register, so an abandoned bus request drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      to_cnt           <= '0;
      eid_q            <= '0;
      prio_q           <= 1'b0;
      status_q         <= '0;
      malformed        <= 1'b0;
      last_seen        <= 1'b0;
      host_ready       <= 1'b0;
      mbus_tx_addr     <= '0;
      mbus_tx_data     <= '0;
      mbus_tx_req      <= 1'b0;
      mbus_tx_pend     <= 1'b0;
      mbus_tx_priority <= 1'b0;
      buffer_request   <= 1'b0;
      buffer_data      <= '0;
      buffer_valid     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (state)
        S_IDLE: begin
          host_ready <= 1'b1;
          if (take) begin
            mbus_tx_addr <= {24'h0, host_data};
            eid_q        <= host_eid;
            prio_q       <= host_priority;
            malformed    <= 1'b0;
            last_seen    <= 1'b0;
            byte_cnt     <= 2'd1;
            if (host_last) begin
              status_q       <= ST_MAL;
              host_ready     <= 1'b0;
              buffer_request <= 1'b1;
              state          <= S_RESP_REQ;
            end else begin
              state <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (take) begin
            mbus_tx_addr <= {mbus_tx_addr[23:0], host_data};
            byte_cnt     <= byte_cnt + 2'd1;
            if (host_last) begin
              status_q       <= ST_MAL;
              host_ready     <= 1'b0;
              buffer_request <= 1'b1;
              state          <= S_RESP_REQ;
            end else if (byte_cnt == 2'd3) begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (mbus_tx_fail) begin
            status_q <= ST_NAK;
            if (take && host_last) begin
              host_ready     <= 1'b0;
              buffer_request <= 1'b1;
              state          <= S_RESP_REQ;
            end else begin
              state <= S_DRAIN;
            end
          end else if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3 || host_last) begin
              mbus_tx_data     <= word_pad;
              mbus_tx_pend     <= !host_last;
              mbus_tx_req      <= 1'b1;
              mbus_tx_priority <= prio_q;
              host_ready       <= 1'b0;
              to_cnt           <= '0;
              byte_cnt         <= 2'd0;
              last_seen        <= host_last;
              if (host_last && byte_cnt != 2'd3) malformed <= 1'b1;
              state <= S_REQ;
            end else begin
              mbus_tx_data <= word_shift;
            end
          end
        end

        S_REQ: begin
          // A fail beats a same-cycle ack; a timeout only fires when no ack arrived.
          if (mbus_tx_fail || (!mbus_tx_ack && to_cnt == TO_LAST)) begin
            mbus_tx_req      <= 1'b0;
            mbus_tx_pend     <= 1'b0;
            mbus_tx_priority <= 1'b0;
            status_q         <= mbus_tx_fail ? ST_NAK : ST_TIMEOUT;
            if (last_seen) begin
              buffer_request <= 1'b1;
              state          <= S_RESP_REQ;
            end else begin
              host_ready <= 1'b1;
              state      <= S_DRAIN;
            end
          end else if (mbus_tx_ack) begin
            mbus_tx_req      <= 1'b0;
            mbus_tx_pend     <= 1'b0;
            mbus_tx_priority <= 1'b0;
            if (mbus_tx_pend) begin
              host_ready <= 1'b1;
              state      <= S_DATA;
            end else begin
              to_cnt <= '0;
              state  <= S_RESULT;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_RESULT: begin
          if (mbus_tx_fail || mbus_tx_succ || to_cnt == TO_LAST) begin
            if (mbus_tx_fail)      status_q <= ST_NAK;
            else if (mbus_tx_succ) status_q <= malformed ? ST_MAL : ST_OK;
            else                   status_q <= ST_TIMEOUT;
            buffer_request <= 1'b1;
            state          <= S_RESP_REQ;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (take && host_last) begin
            host_ready     <= 1'b0;
            buffer_request <= 1'b1;
            state          <= S_RESP_REQ;
          end
        end

        S_RESP_REQ: begin
          if (buffer_grant) begin
            buffer_valid <= 1'b1;
            buffer_data  <= RESP_CODE;
            state        <= S_RESP_CODE;
          end
        end

        S_RESP_CODE: begin
          buffer_data <= eid_q;
          state       <= S_RESP_EID;
        end

        S_RESP_EID: begin
          buffer_data <= status_q;
          state       <= S_RESP_STAT;
        end

        S_RESP_STAT: begin
          buffer_valid   <= 1'b0;
          buffer_data    <= '0;
          buffer_request <= 1'b0;
          host_ready     <= 1'b1;
          state          <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_ice_driver_tx.sv
// Self-checking bench for mbus_ice_driver_tx: table of requests with scoreboarded MBus
// words and response bytes, plus timeout, grant-delay and mid-request reset sequences.
module tb_mbus_ice_driver_tx;

  localparam int TIMEOUT = 16;
  localparam int ACK_DLY = 2;

  typedef enum logic [2:0] {M_OK, M_FAIL1, M_NOACK, M_NOSUCC, M_ACKFAIL, M_BOTH} mode_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [95:0] data;
    logic [4:0]  nbytes;
    logic [7:0]  eid;
    logic        prio;
    mode_t       mode;
    logic [7:0]  status;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  host_data;
  logic        host_valid;
  logic        host_last;
  logic [7:0]  host_eid;
  logic        host_priority;
  logic        host_ready;
  logic [31:0] mbus_tx_addr;
  logic [31:0] mbus_tx_data;
  logic        mbus_tx_req;
  logic        mbus_tx_pend;
  logic        mbus_tx_priority;
  logic        mbus_tx_ack;
  logic        mbus_tx_succ;
  logic        mbus_tx_fail;
  logic        buffer_request;
  logic        buffer_grant;
  logic [7:0]  buffer_data;
  logic        buffer_valid;

  int checks = 0;
  int errors = 0;

  mode_t bus_mode = M_OK;
  int    grant_dly = 1;
  int    last_req_len = 0;
  int    first_valid_cyc = 0;

  logic [65:0] exp_w_q[$];
  logic [7:0]  exp_resp_q[$];
  vec_t        vecs[12];

  always #5 clk = ~clk;

  mbus_ice_driver_tx #(.RESP_CODE(8'h00), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_data(host_data), .host_valid(host_valid), .host_last(host_last),
    .host_eid(host_eid), .host_priority(host_priority), .host_ready(host_ready),
    .mbus_tx_addr(mbus_tx_addr), .mbus_tx_data(mbus_tx_data), .mbus_tx_req(mbus_tx_req),
    .mbus_tx_pend(mbus_tx_pend), .mbus_tx_priority(mbus_tx_priority),
    .mbus_tx_ack(mbus_tx_ack), .mbus_tx_succ(mbus_tx_succ), .mbus_tx_fail(mbus_tx_fail),
    .buffer_request(buffer_request), .buffer_grant(buffer_grant),
    .buffer_data(buffer_data), .buffer_valid(buffer_valid)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_true(input string name, input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: condition not met", name);
    end
  endtask

  // MBus responder: acks each word after ACK_DLY cycles, results per bus_mode.
  initial begin
    int req_cycles = 0;
    int succ_at = 0;
    int fail_at = 0;
    int acks = 0;
    logic [65:0] w;
    mbus_tx_ack = 1'b0; mbus_tx_succ = 1'b0; mbus_tx_fail = 1'b0;
    forever begin
      @(negedge clk);
      mbus_tx_ack = 1'b0; mbus_tx_succ = 1'b0; mbus_tx_fail = 1'b0;
      if (!reset_n) begin
        req_cycles = 0; succ_at = 0; fail_at = 0; acks = 0;
      end else begin
        if (buffer_request) acks = 0;
        if (succ_at > 0) begin
          succ_at--;
          if (succ_at == 0) begin
            mbus_tx_succ = 1'b1;
            if (bus_mode == M_BOTH) mbus_tx_fail = 1'b1;
          end
        end
        if (fail_at > 0) begin
          fail_at--;
          if (fail_at == 0) mbus_tx_fail = 1'b1;
        end
        if (mbus_tx_req) begin
          if (req_cycles == 0) begin
            expect_true("word_expected", exp_w_q.size() != 0);
            if (exp_w_q.size() != 0) begin
              w = exp_w_q.pop_front();
              check("mbus_word", {mbus_tx_addr, mbus_tx_data, mbus_tx_pend, mbus_tx_priority}, w);
            end
          end
          req_cycles++;
          if (bus_mode != M_NOACK && req_cycles == ACK_DLY) begin
            mbus_tx_ack = 1'b1;
            acks++;
            if (bus_mode == M_ACKFAIL) mbus_tx_fail = 1'b1;
            else if (bus_mode == M_FAIL1 && acks == 1) fail_at = 2;
            else if (!mbus_tx_pend && bus_mode != M_NOSUCC) succ_at = 3;
          end
        end else begin
          if (req_cycles > 0) last_req_len = req_cycles;
          req_cycles = 0;
        end
      end
    end
  end

  // Buffer arbiter: grants grant_dly cycles after request, records first strobe cycle.
  initial begin
    int req_cyc = 0;
    bit seen_valid = 1'b0;
    buffer_grant = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n || !buffer_request) begin
        buffer_grant = 1'b0; req_cyc = 0; seen_valid = 1'b0;
      end else begin
        req_cyc++;
        if (buffer_valid && !seen_valid) begin
          first_valid_cyc = req_cyc;
          seen_valid = 1'b1;
        end
        if (req_cyc > grant_dly) buffer_grant = 1'b1;
      end
    end
  end

  // Response byte monitor.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (buffer_valid) begin
          expect_true("resp_byte_expected", exp_resp_q.size() != 0);
          expect_true("valid_under_request", buffer_request);
          if (exp_resp_q.size() != 0) begin
            b = exp_resp_q.pop_front();
            check("resp_byte", buffer_data, b);
          end
        end else if (buffer_request) begin
          check("buf_data_idle_zero", buffer_data, 8'h00);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input bit last);
    int guard = 0;
    host_data = d; host_valid = 1'b1; host_last = last;
    while (!host_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    expect_true("host_ready_wait", host_ready);
    @(negedge clk);
    host_valid = 1'b0; host_last = 1'b0; host_data = 8'h00;
  endtask

  task automatic send_req(input vec_t v);
    host_eid = v.eid; host_priority = v.prio;
    for (int i = 0; i < int'(v.nbytes); i++) begin
      logic [7:0] b;
      if (i < 4) b = v.addr[31-8*i -: 8];
      else       b = v.data[95-8*(i-4) -: 8];
      send_byte(b, i == int'(v.nbytes) - 1);
      if (i == 0) begin
        host_eid = ~v.eid; host_priority = ~v.prio;
      end
    end
  endtask

  task automatic push_expect(input vec_t v);
    int d = int'(v.nbytes) - 4;
    int tot = (d > 0) ? (d + 3) / 4 : 0;
    int nw = tot;
    if ((v.mode == M_FAIL1 || v.mode == M_NOACK) && nw > 1) nw = 1;
    for (int w = 0; w < nw; w++) begin
      int k = (d - 4*w >= 4) ? 4 : d - 4*w;
      logic [31:0] mask = 32'hFFFF_FFFF << (8*(4-k));
      logic [31:0] word = v.data[95-32*w -: 32] & mask;
      exp_w_q.push_back({v.addr, word, (w < tot - 1), v.prio});
    end
    exp_resp_q.push_back(8'h00);
    exp_resp_q.push_back(v.eid);
    exp_resp_q.push_back(v.status);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit done = 1'b0;
    bus_mode = v.mode;
    push_expect(v);
    send_req(v);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = (exp_resp_q.size() == 0) && !buffer_request;
    end
    expect_true($sformatf("vec%0d_response_done", idx), done);
    @(negedge clk);
    check($sformatf("vec%0d_ready_in_idle", idx), host_ready, 1'b1);
    check($sformatf("vec%0d_words_left", idx), exp_w_q.size(), 0);
    check($sformatf("vec%0d_grant_to_strobe", idx), first_valid_cyc, grant_dly + 2);
    if (v.mode == M_NOACK) check($sformatf("vec%0d_req_len", idx), last_req_len, TIMEOUT);
    exp_w_q.delete();
    exp_resp_q.delete();
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    host_data = 8'h00; host_valid = 1'b0; host_last = 1'b0;
    host_eid = 8'h00; host_priority = 1'b0;

    vecs[0]  = '{32'h0000_00A5, {32'hDEAD_BEEF, 64'h0},                      5'd8,  8'h11, 1'b0, M_OK,      8'h00};
    vecs[1]  = '{32'h1234_5678, {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC}, 5'd16, 8'h22, 1'b1, M_OK,      8'h00};
    vecs[2]  = '{32'hCAFE_0001, {32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'h0},         5'd12, 8'h33, 1'b0, M_FAIL1,   8'h01};
    vecs[3]  = '{32'hA1A2_A3A4, {32'h0, 64'h0},                              5'd2,  8'h44, 1'b1, M_OK,      8'h02};
    vecs[4]  = '{32'h0BAD_F00D, {32'hC3D4_7777, 64'h0},                      5'd6,  8'h55, 1'b1, M_OK,      8'h02};
    vecs[5]  = '{32'h0000_0010, {32'h0102_0304, 64'h0},                      5'd8,  8'h66, 1'b0, M_NOACK,   8'h03};
    vecs[6]  = '{32'h0000_0020, {32'h0506_0708, 64'h0},                      5'd8,  8'h77, 1'b1, M_NOSUCC,  8'h03};
    vecs[7]  = '{32'h0000_0030, {32'h090A_0B0C, 64'h0},                      5'd8,  8'h88, 1'b0, M_ACKFAIL, 8'h01};
    vecs[8]  = '{32'h0000_0040, {32'h0D0E_0F10, 64'h0},                      5'd8,  8'h99, 1'b1, M_BOTH,    8'h01};
    vecs[9]  = '{32'hF000_0000, {32'h0, 64'h0},                              5'd1,  8'hAA, 1'b0, M_OK,      8'h02};
    vecs[10] = '{32'h8765_4321, {32'h1357_9BDF, 32'hE1E2_E3E4, 32'h0},         5'd13, 8'hBB, 1'b0, M_OK,      8'h02};
    vecs[11] = '{32'h5555_AAAA, {32'h0, 64'h0},                              5'd4,  8'hCC, 1'b1, M_OK,      8'h02};

    repeat (2) @(negedge clk);
    check("reset_outputs", {host_ready, mbus_tx_addr, mbus_tx_data, mbus_tx_req, mbus_tx_pend,
                            mbus_tx_priority, buffer_request, buffer_data, buffer_valid}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", host_ready, 1'b1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Delayed grant: request must be held and the code byte follows the grant by one cycle.
    grant_dly = 10;
    run_vec(vecs[0], 100);
    check("grant_delay_first_strobe", first_valid_cyc, 12);
    grant_dly = 1;

    // Reset while a word request is outstanding.
    bus_mode = M_NOACK;
    push_expect(vecs[0]);
    send_req(vecs[0]);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      seen = mbus_tx_req;
      if (!seen) @(negedge clk);
    end
    expect_true("rst_req_before", seen);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_req_drop", mbus_tx_req, 1'b0);
    check("rst_bufreq_drop", buffer_request, 1'b0);
    check("rst_ready_drop", host_ready, 1'b0);
    exp_w_q.delete();
    exp_resp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
